// File: rtl/ddr_dimm_rd_responder.sv
// DIMM-side READ responder: queues READs, fetches two cycles ahead of each beat, drives DQ/DQS with pre/postamble.
// Latency RL = AL + CL from command to first beat; no backpressure, READs that cannot be scheduled pulse rd_err.
module ddr_dimm_rd_responder #(
   parameter int DATA_W = 8,
   parameter int COL_W  = 10,
   parameter int QDEPTH = 4,
   parameter int TS_W   = 6
) (
   input  logic                  clock_t,
   input  logic                  reset_n,
   input  logic                  cs_n,
   input  logic                  act_n,
   input  logic                  ras_n,
   input  logic                  cas_n,
   input  logic                  we_n,
   input  logic [1:0]            bg,
   input  logic [1:0]            ba,
   input  logic [COL_W-1:0]      addr,
   input  logic                  a12_bc_n,
   input  logic [1:0]            burst_length,
   input  logic [1:0]            al_dly,
   input  logic [4:0]            cas_dly,
   input  logic                  r_pre,
   output logic                  mem_rd_en,
   output logic [COL_W+3:0]      mem_addr,
   input  logic [2*DATA_W-1:0]   mem_rdata,
   output logic [2*DATA_W-1:0]   dq_out,
   output logic                  dq_oe,
   output logic                  dqs_t,
   output logic                  dqs_c,
   output logic                  dqs_oe,
   output logic                  rd_busy,
   output logic                  rd_err
);

   localparam int AW = COL_W + 4;
   localparam int NE = QDEPTH + 1;

   function automatic logic [TS_W-1:0] f_len(input logic chop);
      return chop ? TS_W'(2) : TS_W'(4);
   endfunction

   logic [TS_W-1:0]     r_cnt;
   logic [QDEPTH-1:0]   r_vld;
   logic [QDEPTH-1:0]   r_chop;
   logic [QDEPTH-1:0]   r_lpre;
   logic [TS_W-1:0]     r_dstart [QDEPTH];
   logic [AW-1:0]       r_base   [QDEPTH];

   logic                r_mem_rd_en;
   logic [AW-1:0]       r_mem_addr;
   logic [2*DATA_W-1:0] r_dq_out;
   logic                r_dq_oe;
   logic                r_dqs_t;
   logic                r_dqs_c;
   logic                r_dqs_oe;
   logic                r_rd_busy;
   logic                r_rd_err;

   logic                w_is_rd;
   logic [4:0]          w_al;
   logic [6:0]          w_rl;
   logic                w_new_chop;
   logic [TS_W-1:0]     w_new_d;
   logic [TS_W-1:0]     w_now1;
   logic [AW-1:0]       w_new_base;

   logic [QDEPTH-1:0]   w_live;
   logic [QDEPTH-1:0]   w_slot;
   logic                w_ovl;
   logic                w_acc;
   logic                w_err;
   logic [TS_W-1:0]     w_gap_a [QDEPTH];
   logic [TS_W-1:0]     w_gap_b [QDEPTH];

   logic [NE-1:0]       w_ev;
   logic [NE-1:0]       w_echop;
   logic [NE-1:0]       w_epre;
   logic [TS_W-1:0]     w_ed   [NE];
   logic [AW-1:0]       w_eb   [NE];
   logic [TS_W-1:0]     w_edf  [NE];
   logic [TS_W-1:0]     w_fx   [NE];
   logic [TS_W-1:0]     w_lead [NE];

   logic                w_fetch;
   logic [AW-1:0]       w_faddr;
   logic                w_data;
   logic                w_pre;

   always_comb begin
      w_is_rd = !cs_n && act_n && ras_n && !cas_n && we_n;
      case (al_dly)
         2'b01:   w_al = cas_dly - 5'd1;
         2'b10:   w_al = cas_dly - 5'd2;
         default: w_al = 5'd0;
      endcase
      w_rl       = {2'b00, cas_dly} + {2'b00, w_al};
      w_new_chop = (burst_length == 2'b10) || (burst_length == 2'b01 && !a12_bc_n);
      w_now1     = r_cnt + TS_W'(1);
      w_new_d    = r_cnt + TS_W'(w_rl);
      w_new_base = {bg, ba, addr} & ~(w_new_chop ? AW'(3) : AW'(7));
   end

   // An entry whose last beat is the current cycle retires at this edge, so its slot is reusable now.
   always_comb begin
      w_live = '0;
      w_slot = '0;
      w_ovl  = 1'b0;
      for (int i = QDEPTH - 1; i >= 0; i--) begin
         w_gap_a[i] = w_new_d - r_dstart[i];
         w_gap_b[i] = r_dstart[i] - w_new_d;
         w_live[i]  = r_vld[i] && ((w_now1 - r_dstart[i]) != f_len(r_chop[i]));
         if (w_live[i] && ((w_gap_a[i] < f_len(r_chop[i])) || (w_gap_b[i] < f_len(w_new_chop))))
            w_ovl = 1'b1;
         if (!w_live[i])
            w_slot = QDEPTH'(1) << i;
      end
      w_acc = w_is_rd && !(&w_live) && (w_rl >= 7'd3) && !w_ovl;
      w_err = w_is_rd && !w_acc;
   end

   // The incoming READ joins the scan so RL=3 can fetch/preamble in the very next cycle.
   always_comb begin
      for (int i = 0; i < QDEPTH; i++) begin
         w_ev[i]    = r_vld[i];
         w_echop[i] = r_chop[i];
         w_epre[i]  = r_lpre[i];
         w_ed[i]    = r_dstart[i];
         w_eb[i]    = r_base[i];
      end
      w_ev[QDEPTH]    = w_acc;
      w_echop[QDEPTH] = w_new_chop;
      w_epre[QDEPTH]  = r_pre;
      w_ed[QDEPTH]    = w_new_d;
      w_eb[QDEPTH]    = w_new_base;
   end

   always_comb begin
      w_fetch = 1'b0;
      w_faddr = '0;
      w_data  = 1'b0;
      w_pre   = 1'b0;
      for (int i = 0; i < NE; i++) begin
         w_edf[i]  = w_now1 - w_ed[i];
         w_fx[i]   = w_edf[i] + TS_W'(2);
         w_lead[i] = w_ed[i] - w_now1;
         if (w_ev[i]) begin
            if (w_fx[i] < f_len(w_echop[i])) begin
               w_fetch = 1'b1;
               w_faddr = w_eb[i] + AW'({w_fx[i][1:0], 1'b0});
            end
            if (w_edf[i] < f_len(w_echop[i]))
               w_data = 1'b1;
            if ((w_lead[i] == TS_W'(1)) || (w_epre[i] && (w_lead[i] == TS_W'(2))))
               w_pre = 1'b1;
         end
      end
   end

   // Data beats win over preamble/postamble, which is what makes back-to-back bursts seamless.
   always_ff @(posedge clock_t or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt       <= '0;
         r_vld       <= '0;
         r_chop      <= '0;
         r_lpre      <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            r_dstart[i] <= '0;
            r_base[i]   <= '0;
         end
         r_mem_rd_en <= 1'b0;
         r_mem_addr  <= '0;
         r_dq_out    <= '0;
         r_dq_oe     <= 1'b0;
         r_dqs_t     <= 1'b0;
         r_dqs_c     <= 1'b0;
         r_dqs_oe    <= 1'b0;
         r_rd_busy   <= 1'b0;
         r_rd_err    <= 1'b0;
      end else begin
         r_cnt <= w_now1;
         for (int i = 0; i < QDEPTH; i++) begin
            if (w_acc && w_slot[i]) begin
               r_vld[i]    <= 1'b1;
               r_chop[i]   <= w_new_chop;
               r_lpre[i]   <= r_pre;
               r_dstart[i] <= w_new_d;
               r_base[i]   <= w_new_base;
            end else begin
               r_vld[i]    <= w_live[i];
            end
         end
         r_mem_rd_en <= w_fetch;
         r_mem_addr  <= w_faddr;
         r_dq_out    <= w_data ? mem_rdata : '0;
         r_dq_oe     <= w_data;
         r_dqs_t     <= w_data;
         r_dqs_c     <= !w_data && (w_pre || r_dq_oe);
         r_dqs_oe    <= w_data || w_pre || r_dq_oe;
         r_rd_busy   <= (|w_live) || w_acc;
         r_rd_err    <= w_err;
      end
   end

   assign mem_rd_en = r_mem_rd_en;
   assign mem_addr  = r_mem_addr;
   assign dq_out    = r_dq_out;
   assign dq_oe     = r_dq_oe;
   assign dqs_t     = r_dqs_t;
   assign dqs_c     = r_dqs_c;
   assign dqs_oe    = r_dqs_oe;
   assign rd_busy   = r_rd_busy;
   assign rd_err    = r_rd_err;

endmodule

// File: tb/tb_ddr_dimm_rd_responder.sv
// Bench for ddr_dimm_rd_responder: directed READ scenarios then randomized traffic,
// compared cycle by cycle against a per-cycle expectation map built from the READ timing rules.
module tb_ddr_dimm_rd_responder;

   localparam int DATA_W = 8;
   localparam int COL_W  = 10;
   localparam int QDEPTH = 4;
   localparam int TS_W   = 6;
   localparam int AW     = COL_W + 4;
   localparam int NC     = 4096;

   logic              clock_t = 1'b0;
   logic              reset_n;
   logic              cs_n, act_n, ras_n, cas_n, we_n;
   logic [1:0]        bg, ba;
   logic [COL_W-1:0]  addr;
   logic              a12_bc_n;
   logic [1:0]        burst_length, al_dly;
   logic [4:0]        cas_dly;
   logic              r_pre;
   logic              mem_rd_en;
   logic [AW-1:0]     mem_addr;
   logic [15:0]       mem_rdata;
   logic [15:0]       dq_out;
   logic              dq_oe, dqs_t, dqs_c, dqs_oe, rd_busy, rd_err;

   always #5 clock_t = ~clock_t;

   ddr_dimm_rd_responder #(
      .DATA_W(DATA_W), .COL_W(COL_W), .QDEPTH(QDEPTH), .TS_W(TS_W)
   ) dut (
      .clock_t(clock_t), .reset_n(reset_n),
      .cs_n(cs_n), .act_n(act_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
      .bg(bg), .ba(ba), .addr(addr), .a12_bc_n(a12_bc_n),
      .burst_length(burst_length), .al_dly(al_dly), .cas_dly(cas_dly), .r_pre(r_pre),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .dq_out(dq_out), .dq_oe(dq_oe), .dqs_t(dqs_t), .dqs_c(dqs_c), .dqs_oe(dqs_oe),
      .rd_busy(rd_busy), .rd_err(rd_err)
   );

   int           n_checks = 0;
   int           n_fail   = 0;
   int           cyc      = 0;
   int           b;
   bit           rst_now;

   // expected behaviour per absolute bench cycle
   bit           x_fetch [NC];
   bit           x_data  [NC];
   bit           x_pre   [NC];
   bit           x_err   [NC];
   bit           x_busy  [NC];
   logic [AW-1:0] x_addr [NC];
   logic [15:0]  x_dq    [NC];

   logic [15:0]  mem_arr [1 << AW];
   int           q_d[$];
   int           q_last[$];
   bit           prev_en;
   logic [AW-1:0] prev_addr;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, act, exp);
      end
   endtask

   task automatic check_cycle();
      bit e_fetch, e_data, e_pre, e_prev, e_err, e_busy, e_oe;
      e_fetch = 0; e_data = 0; e_pre = 0; e_prev = 0; e_err = 0; e_busy = 0;
      if (!rst_now) begin
         e_fetch = x_fetch[cyc];
         e_data  = x_data[cyc];
         e_pre   = x_pre[cyc];
         e_prev  = (cyc > 0) ? x_data[cyc-1] : 1'b0;
         e_err   = x_err[cyc];
         e_busy  = x_busy[cyc];
      end
      e_oe = e_data | e_pre | e_prev;
      check_eq("mem_rd_en", 32'(mem_rd_en), 32'(e_fetch));
      check_eq("mem_addr",  32'(mem_addr),  e_fetch ? 32'(x_addr[cyc]) : 32'd0);
      check_eq("dq_oe",     32'(dq_oe),     32'(e_data));
      check_eq("dq_out",    32'(dq_out),    e_data ? 32'(x_dq[cyc]) : 32'd0);
      check_eq("dqs_oe",    32'(dqs_oe),    32'(e_oe));
      check_eq("dqs_t",     32'(dqs_t),     32'(e_data));
      check_eq("dqs_c",     32'(dqs_c),     32'(e_oe & !e_data));
      check_eq("rd_busy",   32'(rd_busy),   32'(e_busy));
      check_eq("rd_err",    32'(rd_err),    32'(e_err));
   endtask

   task automatic set_idle_pins();
      cs_n = 1'b1; act_n = 1'b1; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1;
      bg = 2'($urandom); ba = 2'($urandom); addr = 10'($urandom); a12_bc_n = 1'($urandom);
   endtask

   // one clock: check the new cycle, play the backing store, release the command pins
   task automatic tick();
      @(posedge clock_t);
      cyc++;
      #1;
      check_cycle();
      mem_rdata = prev_en ? mem_arr[prev_addr] : 16'($urandom);
      prev_en   = mem_rd_en;
      prev_addr = mem_addr;
      set_idle_pins();
   endtask

   task automatic run_to(input int c);
      while (cyc < c) tick();
   endtask

   task automatic set_mode(input int bl, input int al, input int cl, input int pre);
      burst_length = 2'(bl); al_dly = 2'(al); cas_dly = 5'(cl); r_pre = 1'(pre);
   endtask

   // reference: schedule a READ seen in the current cycle using the mode pins as driven now
   task automatic model_issue();
      int cl, al, rl, len, d, last, t;
      bit chop, ovl;
      logic [AW-1:0] base;
      t  = cyc;
      cl = int'(cas_dly);
      case (al_dly)
         2'b01:   al = cl - 1;
         2'b10:   al = cl - 2;
         default: al = 0;
      endcase
      rl   = cl + al;
      chop = (burst_length == 2'b10) || (burst_length == 2'b01 && !a12_bc_n);
      len  = chop ? 2 : 4;
      d    = t + rl;
      last = d + len - 1;
      for (int i = q_last.size() - 1; i >= 0; i--)
         if (q_last[i] <= t) begin
            q_last.delete(i);
            q_d.delete(i);
         end
      ovl = 0;
      foreach (q_d[i])
         if (d <= q_last[i] && last >= q_d[i]) ovl = 1;
      if (q_d.size() >= QDEPTH || rl < 3 || ovl) begin
         x_err[t+1] = 1;
      end else begin
         q_d.push_back(d);
         q_last.push_back(last);
         base = {bg, ba, addr};
         base = chop ? {base[AW-1:2], 2'b00} : {base[AW-1:3], 3'b000};
         for (int k = 0; k < len; k++) begin
            x_data[d+k]    = 1;
            x_fetch[d+k-2] = 1;
            x_addr[d+k-2]  = base + AW'(2 * k);
            x_dq[d+k]      = mem_arr[base + AW'(2 * k)];
         end
         x_pre[d-1] = 1;
         if (r_pre) x_pre[d-2] = 1;
         for (int c = t + 1; c <= last; c++) x_busy[c] = 1;
      end
   endtask

   task automatic rd(input logic [1:0] g, input logic [1:0] k, input logic [9:0] col, input logic a12);
      cs_n = 1'b0; act_n = 1'b1; ras_n = 1'b1; cas_n = 1'b0; we_n = 1'b1;
      bg = g; ba = k; addr = col; a12_bc_n = a12;
      model_issue();
   endtask

   // asynchronous reset in the middle of the current cycle, held for two edges
   task automatic async_reset();
      reset_n = 1'b0;
      rst_now = 1'b1;
      #1;
      check_eq("arst_dq_oe",     32'(dq_oe),     32'd0);
      check_eq("arst_dqs_oe",    32'(dqs_oe),    32'd0);
      check_eq("arst_mem_rd_en", 32'(mem_rd_en), 32'd0);
      check_eq("arst_dq_out",    32'(dq_out),    32'd0);
      for (int c = cyc; c < NC; c++) begin
         x_fetch[c] = 0; x_data[c] = 0; x_pre[c] = 0; x_err[c] = 0; x_busy[c] = 0;
      end
      q_d.delete();
      q_last.delete();
      prev_en = 0;
      tick();
      tick();
      reset_n = 1'b1;
      rst_now = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      rst_now = 1'b1;
      prev_en = 0;
      prev_addr = '0;
      mem_rdata = '0;
      set_idle_pins();
      set_mode(0, 0, 4, 0);
      for (int i = 0; i < (1 << AW); i++) mem_arr[i] = 16'($urandom);

      // reset held through cycle 3
      tick(); tick(); tick();
      reset_n = 1'b1;
      rst_now = 1'b0;

      // single BL8
      b = cyc; run_to(b + 10); rd(2'd0, 2'd1, 10'h010, 1'b1); run_to(b + 30);
      // seamless pair
      b = cyc; run_to(b + 10); rd(2'd0, 2'd1, 10'h010, 1'b1);
      run_to(b + 14); rd(2'd2, 2'd3, 10'h3F8, 1'b1); run_to(b + 32);
      // BC4 on the fly, 2-clock preamble
      set_mode(1, 0, 4, 1);
      b = cyc; run_to(b + 10); rd(2'd0, 2'd1, 10'h016, 1'b0); run_to(b + 25);
      // data window conflict
      set_mode(0, 0, 4, 0);
      b = cyc; run_to(b + 10); rd(2'd1, 2'd0, 10'h100, 1'b1);
      run_to(b + 12); rd(2'd1, 2'd0, 10'h200, 1'b1); run_to(b + 30);
      // queue overflow at RL=47
      set_mode(0, 1, 24, 0);
      b = cyc;
      for (int k = 0; k < 5; k++) begin
         run_to(b + 4 * k); rd(2'(k), 2'(k), 10'(16 * k), 1'b1);
      end
      run_to(b + 70);
      // full queue accepts in the cycle its head retires
      b = cyc;
      for (int k = 0; k < 4; k++) begin
         run_to(b + 4 * k); rd(2'(k), 2'(3 - k), 10'(40 * k), 1'b1);
      end
      run_to(b + 49); rd(2'd3, 2'd3, 10'h0A0, 1'b1);
      run_to(b + 50); rd(2'd2, 2'd2, 10'h0B0, 1'b1);
      run_to(b + 110);
      // RL boundary: 3 accepted, 2 and 1 dropped
      set_mode(0, 0, 3, 1);
      b = cyc; run_to(b + 5); rd(2'd1, 2'd1, 10'h044, 1'b1);
      run_to(b + 15); cas_dly = 5'd2; rd(2'd1, 2'd1, 10'h048, 1'b1);
      run_to(b + 20); cas_dly = 5'd1; rd(2'd1, 2'd1, 10'h04C, 1'b1);
      run_to(b + 30);
      // reset in the middle of a BL8 burst
      set_mode(0, 0, 4, 0);
      b = cyc; run_to(b + 10); rd(2'd0, 2'd1, 10'h010, 1'b1);
      run_to(b + 15); async_reset(); run_to(b + 35);

      // randomized traffic with mode pins changing every cycle
      for (int n = 0; n < 1500; n++) begin
         int r;
         tick();
         set_mode($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(4, 10), $urandom_range(0, 1));
         r = $urandom_range(0, 99);
         if (r < 30) begin
            rd(2'($urandom), 2'($urandom), 10'($urandom), 1'($urandom));
         end else if (r < 34) begin
            al_dly = 2'd0; cas_dly = 5'($urandom_range(1, 3));
            rd(2'($urandom), 2'($urandom), 10'($urandom), 1'($urandom));
         end else if (r < 44) begin
            cs_n = 1'($urandom); act_n = 1'($urandom); ras_n = 1'($urandom);
            cas_n = 1'($urandom); we_n = 1'($urandom);
            if (!cs_n && act_n && ras_n && !cas_n && we_n) model_issue();
         end
         if (n == 750) async_reset();
      end
      run_to(cyc + 60);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ddr_dimm_rd_responder.md
Name: ddr_dimm_rd_responder

Overview:
DIMM-side read-data responder: the device end of the read path whose command end is driven by DDR_TOP. Decodes READ commands on the DDR command pins, schedules each burst at read latency RL = AL + CL, and fetches data from the DIMM backing store. Drives DQ/DQS with preamble and postamble, merging back-to-back bursts seamlessly. Sits inside DIMM_MODEL beside the write capture path; MEMORY_CHECK observes its DQ output.

Parameters:
DATA_W, 8, device DQ width (x8); dq_out carries two beats per clock
COL_W, 10, column address width
QDEPTH, 4, maximum outstanding READs (issued, last data cycle not yet driven)
TS_W, 6, width of free-running cycle counter and timestamps; RL + 4 < 2**TS_W

Ports:
clock_t  in  1  device clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
cs_n, act_n, ras_n, cas_n, we_n  in  1 each  DDR4 command pins
bg  in  2  bank group
ba  in  2  bank address
addr  in  COL_W  column address
a12_bc_n  in  1  on-the-fly burst chop (0 = BC4)
burst_length  in  2  MR0 BL: 00 BL8, 01 on-the-fly, 10 BC4
al_dly  in  2  MR1 AL: 00 AL=0, 01 AL=CL-1, 10 AL=CL-2, 11 treated as 00
cas_dly  in  5  CL in clocks, legal 4..24
r_pre  in  1  read preamble: 0 = 1 clock, 1 = 2 clocks
mem_rd_en  out  1  backing-store fetch strobe
mem_addr  out  4+COL_W  {bg,ba,col}
mem_rdata  in  2*DATA_W  fetch data, valid the cycle after mem_rd_en; [DATA_W-1:0] = rising beat
dq_out  out  2*DATA_W  read data, two beats per clock
dq_oe  out  1  DQ drive enable
dqs_t, dqs_c  out  1 each  strobe level (dqs_t=1 means toggle this clock)
dqs_oe  out  1  DQS drive enable
rd_busy  out  1  queue non-empty
rd_err  out  1  one-cycle pulse, READ dropped

Behaviour:
- Reset (async, mid-burst included): queue flushed, counter 0; every output 0 except dqs_c=0. Output drive stops immediately.
- READ decode: cs_n=0, act_n=1, ras_n=1, cas_n=0, we_n=1, sampled at rising edge T. All other encodings are ignored.
- Per-command capture at T: RL, bg/ba/col, chop = (burst_length==10) | (burst_length==01 & !a12_bc_n). Later changes to mode inputs do not affect queued READs.
- Data start D = T + RL. Data cycles: D..D+3 for BL8, D..D+1 for BC4.
- Fetch: mem_rd_en in cycle d-2 for each data cycle d. mem_rdata is registered into dq_out for cycle d.
- Fetch addresses: BL8 col base {col[9:3],000}, +2 per fetch. BC4 base {col[9:2],00}, +2.
- Preamble: dqs_oe=1, dqs_t=0, dqs_c=1 for cycle D-1, plus cycle D-2 when r_pre=1.
- Data cycles: dq_oe=1, dqs_oe=1, dqs_t=1, dqs_c=0.
- Postamble: one cycle after the last data cycle, with dqs_oe=1 and dqs_t=0; then both enables drop to 0.
- Seamless bursts: if a burst's D equals the previous burst's last data cycle + 1, no postamble and no preamble are inserted. Enables stay high.
- Preamble collision: preamble cycles that overlap the previous burst's data or postamble cycles are suppressed.
- State per queue entry: IDLE → WAIT (counter ≠ D-2-pre) → FETCH → DRIVE → free after the last data cycle. The queue is in-order and one burst drives at a time.
- rd_err (asserted in T+1; READ dropped, no queue entry):
  - queue full (QDEPTH outstanding);
  - RL < 3;
  - new data window overlaps the previous entry's data cycles.
- Simultaneous free and accept in the same cycle is legal. Free happens first, so a full queue accepts.
- Timestamp comparisons are mod 2**TS_W; counter wrap is transparent.
- rd_busy = queue non-empty (registered).

Test Plan:
- Reset: reset_n=0 at cycle 0 → all outputs 0. Release at cycle 3 → outputs remain 0, rd_busy=0.
- Single BL8: CL=4, AL=0, r_pre=0; READ at cycle 10, bg=0, ba=1, col=0x010.
  - mem_rd_en cycles 12..15, addr 0x0410/0x0412/0x0414/0x0416.
  - Preamble at 13, dq_oe 14..17, postamble 18, dqs_oe=0 at 19.
- Seamless: same settings, READs at 10 and 14.
  - dq_oe continuous 14..21, no postamble at 18.
  - Postamble at 22, rd_err never asserted.
- BC4 on the fly: burst_length=01, a12_bc_n=0, col=0x016, r_pre=1, READ at 10.
  - Fetch 0x0414, 0x0416 at 12, 13.
  - Preamble 12..13, data 14..15, postamble 16.
- Conflict: READ at 10 and 12 with BL8, RL=4 → second dropped, rd_err=1 in cycle 13 only. First burst unaffected.
- Overflow: CL=24, AL=01 (RL=47); READs at 0, 4, 8, 12, 16.
  - 5th dropped, rd_err at 17.
  - Data cycles 47..62 seamless; rd_busy falls at 63.
- Reset mid-burst: reset_n=0 during cycle 15 of the single BL8 case → dq_oe/dqs_oe 0 immediately, no further mem_rd_en.
